complex_add_acc: RTL and testbench

COMPLEX_ADD_ACC -- requirements
Module: complex_add_acc

---
 rtl/complex_add_acc.sv | 157 +++++++++++++++
 tb/tb_complex_add_acc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_add_acc.sv
// Complex adder/subtractor with an accumulate mode, optional saturation,
// a sticky overflow flag and a one-deep registered valid/ready output stage.
module complex_add_acc #(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned SAT       = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  input  logic [SIZE-1:0]  a_real,
  input  logic [SIZE-1:0]  a_imag,
  input  logic [SIZE-1:0]  b_real,
  input  logic [SIZE-1:0]  b_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  sum_real,
  output logic [SIZE-1:0]  sum_imag,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] acc_count
);

  // Fixed-point scaling is purely an interpretation of the bits; no path needs it.
  logic unused_frac;
  assign unused_frac = |32'(FRAC_BITS);

  logic             out_valid_q, out_valid_d;
  logic [SIZE-1:0]  sum_real_q, sum_real_d;
  logic [SIZE-1:0]  sum_imag_q, sum_imag_d;
  logic             ovf_q, ovf_d;
  logic [SIZE-1:0]  acc_real_q, acc_real_d;
  logic [SIZE-1:0]  acc_imag_q, acc_imag_d;
  logic [CNT_W-1:0] acc_count_q, acc_count_d;

  logic            accept;
  logic [SIZE-1:0] x_real, x_imag, y_real, y_imag;
  logic            sub_real, sub_imag;
  logic [SIZE:0]   real_wide, imag_wide;
  logic            ovf_real, ovf_imag;
  logic [SIZE-1:0] res_real, res_imag;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Clamp or wrap a SIZE+1 bit result back to SIZE bits.
  function automatic logic [SIZE-1:0] fit(input logic [SIZE:0] w);
    logic [SIZE-1:0] r;
    r = w[SIZE-1:0];
    if ((SAT != 0) && (w[SIZE] != w[SIZE-1])) begin
      r = w[SIZE] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
    end
    return r;
  endfunction

  // Operand selection per mode; mode 10 adds a to the accumulator (or zero).
  always_comb begin
    x_real   = a_real;
    x_imag   = a_imag;
    y_real   = b_real;
    y_imag   = b_imag;
    sub_real = 1'b0;
    sub_imag = 1'b0;
    unique case (mode)
      2'b00: ;
      2'b01: begin
        sub_real = 1'b1;
        sub_imag = 1'b1;
      end
      2'b10: begin
        x_real = acc_clr ? '0 : acc_real_q;
        x_imag = acc_clr ? '0 : acc_imag_q;
        y_real = a_real;
        y_imag = a_imag;
      end
      2'b11: sub_imag = 1'b1;
      default: ;
    endcase
  end

  // One extra bit of headroom so overflow shows as disagreeing top bits.
  always_comb begin
    real_wide = sub_real ? ({x_real[SIZE-1], x_real} - {y_real[SIZE-1], y_real})
                         : ({x_real[SIZE-1], x_real} + {y_real[SIZE-1], y_real});
    imag_wide = sub_imag ? ({x_imag[SIZE-1], x_imag} - {y_imag[SIZE-1], y_imag})
                         : ({x_imag[SIZE-1], x_imag} + {y_imag[SIZE-1], y_imag});
    ovf_real  = real_wide[SIZE] ^ real_wide[SIZE-1];
    ovf_imag  = imag_wide[SIZE] ^ imag_wide[SIZE-1];
    res_real  = fit(real_wide);
    res_imag  = fit(imag_wide);
  end

  // Next-state: load on accept, drain on handshake, sticky overflow.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_real_d  = sum_real_q;
    sum_imag_d  = sum_imag_q;
    ovf_d       = ovf_q;
    acc_real_d  = acc_real_q;
    acc_imag_d  = acc_imag_q;
    acc_count_d = acc_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      sum_real_d  = res_real;
      sum_imag_d  = res_imag;
      if (mode == 2'b10) begin
        acc_real_d = res_real;
        acc_imag_d = res_imag;
        if (acc_clr) begin
          acc_count_d = CNT_W'(1);
        end else if (!(&acc_count_q)) begin
          acc_count_d = acc_count_q + CNT_W'(1);
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Set wins over a simultaneous clear.
    if (accept && (ovf_real || ovf_imag)) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_real_q  <= '0;
      sum_imag_q  <= '0;
      ovf_q       <= 1'b0;
      acc_real_q  <= '0;
      acc_imag_q  <= '0;
      acc_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_real_q  <= sum_real_d;
      sum_imag_q  <= sum_imag_d;
      ovf_q       <= ovf_d;
      acc_real_q  <= acc_real_d;
      acc_imag_q  <= acc_imag_d;
      acc_count_q <= acc_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_real  = sum_real_q;
  assign sum_imag  = sum_imag_q;
  assign ovf       = ovf_q;
  assign acc_count = acc_count_q;

endmodule

// File: tb/tb_complex_add_acc.sv
// Scoreboard bench for complex_add_acc: a saturating and a wrapping instance
// share stimulus; expected results are queued on accept and popped on output.
module tb_complex_add_acc;

  logic        clk, rst_n;
  logic        in_valid, acc_clr, out_ready, ovf_clr;
  logic [1:0]  mode;
  logic [15:0] a_real, a_imag, b_real, b_imag;

  logic        in_ready, out_valid, ovf;
  logic [15:0] sum_real, sum_imag;
  logic [7:0]  acc_count;
  logic        in_ready_w, out_valid_w, ovf_w;
  logic [15:0] sum_real_w, sum_imag_w;
  logic [7:0]  acc_count_w;

  complex_add_acc #(.SIZE(16), .FRAC_BITS(8), .SAT(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .acc_clr(acc_clr), .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_valid(out_valid), .out_ready(out_ready), .sum_real(sum_real), .sum_imag(sum_imag),
    .ovf(ovf), .ovf_clr(ovf_clr), .acc_count(acc_count)
  );

  complex_add_acc #(.SIZE(16), .FRAC_BITS(8), .SAT(0), .CNT_W(8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .mode(mode),
    .acc_clr(acc_clr), .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_valid(out_valid_w), .out_ready(out_ready), .sum_real(sum_real_w),
    .sum_imag(sum_imag_w), .ovf(ovf_w), .ovf_clr(ovf_clr), .acc_count(acc_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sr, si, wr, wi;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_acc_r[2];
  logic [15:0] m_acc_i[2];
  int          cnt_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic void calc(input int x, input int y, input bit sub, input bit sat,
                               output logic [15:0] r);
    int t;
    t = sub ? x - y : x + y;
    if (sat && t > 32767) r = 16'h7fff;
    else if (sat && t < -32768) r = 16'h8000;
    else r = t[15:0];
  endfunction

  // Reference model: index 0 saturates, index 1 wraps.
  task automatic model_push(input logic [1:0] m, input logic c, input logic [15:0] ar,
                            input logic [15:0] ai, input logic [15:0] br,
                            input logic [15:0] bi);
    exp_t        e;
    logic [15:0] rr[2];
    logic [15:0] ri[2];
    for (int i = 0; i < 2; i++) begin
      int xr, xi, yr, yi;
      bit sr, si;
      xr = s16(ar); xi = s16(ai); yr = s16(br); yi = s16(bi);
      sr = (m == 2'b01);
      si = (m == 2'b01) || (m == 2'b11);
      if (m == 2'b10) begin
        xr = c ? 0 : s16(m_acc_r[i]);
        xi = c ? 0 : s16(m_acc_i[i]);
        yr = s16(ar);
        yi = s16(ai);
      end
      calc(xr, yr, sr, (i == 0), rr[i]);
      calc(xi, yi, si, (i == 0), ri[i]);
      if (m == 2'b10) begin
        m_acc_r[i] = rr[i];
        m_acc_i[i] = ri[i];
      end
    end
    if (m == 2'b10) cnt_m = c ? 1 : ((cnt_m == 255) ? 255 : cnt_m + 1);
    e.sr = rr[0]; e.si = ri[0]; e.wr = rr[1]; e.wi = ri[1];
    sb.push_back(e);
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      m_acc_r[i] = '0;
      m_acc_i[i] = '0;
    end
    cnt_m = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [1:0] m, input logic c, input logic [15:0] ar,
                      input logic [15:0] ai, input logic [15:0] br, input logic [15:0] bi);
    mode = m; acc_clr = c; a_real = ar; a_imag = ai; b_real = br; b_imag = bi;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        model_push(m, c, ar, ai, br, bi);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("acc_count", acc_count, cnt_m);
        return;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Output monitor: the handshake seen at a negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sat_real", sum_real, e.sr);
        check("sat_imag", sum_imag, e.si);
        check("wrap_real", sum_real_w, e.wr);
        check("wrap_imag", sum_imag_w, e.wi);
        check("wrap_valid", out_valid_w, 1'b1);
      end
    end
  end

  initial begin
    time t0;
    rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    mode = 2'b00; a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    model_reset();
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", {sum_real, sum_imag}, 32'h0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_acc_count", acc_count, 8'h0);
    check("rst_in_ready", in_ready, 1'b1);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic modes.
    send(2'b00, 1'b0, 16'h0100, 16'h0200, 16'h0080, 16'hff00);
    check("m00", {out_valid, sum_real, sum_imag}, {1'b1, 16'h0180, 16'h0100});
    check("m00_ovf", ovf, 1'b0);
    send(2'b01, 1'b0, 16'h0100, 16'h0200, 16'h0080, 16'hff00);
    check("m01", {sum_real, sum_imag}, {16'h0080, 16'h0300});
    send(2'b11, 1'b0, 16'h0100, 16'h0200, 16'h0080, 16'hff00);
    check("m11", {sum_real, sum_imag}, {16'h0180, 16'h0300});

    // Overflow: saturate vs wrap, sticky flag, set beats clear.
    send(2'b00, 1'b0, 16'h7000, 16'h9000, 16'h2000, 16'he000);
    check("ovf_sat", {sum_real, sum_imag}, {16'h7fff, 16'h8000});
    check("ovf_wrap", {sum_real_w, sum_imag_w}, {16'h9000, 16'h7000});
    check("ovf_set", {ovf, ovf_w}, 2'b11);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);
    ovf_clr = 1'b1;
    send(2'b00, 1'b0, 16'h7000, 16'h9000, 16'h2000, 16'he000);
    ovf_clr = 1'b0;
    check("ovf_set_wins", ovf, 1'b1);

    // Accumulate.
    send(2'b10, 1'b1, 16'h0100, 16'hff00, 16'h0000, 16'h0000);
    check("acc1", {sum_real, sum_imag}, {16'h0100, 16'hff00});
    send(2'b10, 1'b0, 16'h0100, 16'hff00, 16'h0000, 16'h0000);
    check("acc2", {sum_real, sum_imag}, {16'h0200, 16'hfe00});
    send(2'b10, 1'b0, 16'h0100, 16'hff00, 16'h0000, 16'h0000);
    check("acc3", {sum_real, sum_imag}, {16'h0300, 16'hfd00});
    check("acc3_count", acc_count, 8'd3);
    // Non-accumulate modes leave acc and count untouched.
    send(2'b00, 1'b1, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    send(2'b10, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check("acc_kept", {sum_real, sum_imag, acc_count}, {16'h0300, 16'hfd00, 8'd4});
    for (int i = 0; i < 260; i++) send(2'b10, 1'b0, 16'h0001, 16'h0000, 16'h0, 16'h0);
    check("count_hold", acc_count, 8'hff);

    // Backpressure then back-to-back accept-and-drain.
    send(2'b00, 1'b0, 16'h0011, 16'h0022, 16'h0001, 16'h0002);
    out_ready = 1'b0;
    mode = 2'b01; acc_clr = 1'b0;
    a_real = 16'h0500; a_imag = 16'h0600; b_real = 16'h0100; b_imag = 16'h0200;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_hold", {out_valid, sum_real, sum_imag}, {1'b1, 16'h0012, 16'h0024});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b01, 1'b0, 16'h0500, 16'h0600, 16'h0100, 16'h0200);
    check("stall_next", {sum_real, sum_imag}, {16'h0400, 16'h0400});
    t0 = $time;
    send(2'b00, 1'b0, 16'h1000, 16'h2000, 16'h0001, 16'h0002);
    send(2'b11, 1'b0, 16'h1000, 16'h2000, 16'h0001, 16'h0002);
    check("b2b_time", 64'($time - t0), 64'd20);

    // Random traffic with random backpressure and idle cycles.
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom));
    end
    out_ready = 1'b1;

    // Asynchronous reset while a result is held and acc is nonzero.
    send(2'b10, 1'b1, 16'h0123, 16'h0456, 16'h0000, 16'h0000);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", {out_valid, sum_real, sum_imag}, 33'h0);
    check("mid_rst_state", {ovf, acc_count, in_ready}, {1'b0, 8'h0, 1'b1});
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b10, 1'b0, 16'h0055, 16'h0066, 16'h0000, 16'h0000);
    check("post_rst_acc", {sum_real, sum_imag}, {16'h0055, 16'h0066});

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
